// File: rtl/channel_accum_blk_pkg.sv
// Shared definitions for the channel accumulator: default lane width,
// FSM state encodings and the partial-sum BRAM read latency.

`ifndef DW
`define DW 16
`endif

package channel_accum_blk_pkg;

    // Cycles from address/sel to i_psum_data.
    localparam int PSUM_RD_LAT = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/channel_accum_blk_lane_act_sat.sv
// lane_act_sat: combinational reduction of one accumulator lane to DW bits.
// Build option ACCUM_RELU_EN: when defined, negative sums clamp to 0 (ReLU)
// and positive sums saturate to the DW max. When undefined, the result is a
// plain signed saturation to the DW range.

module lane_act_sat #(
    parameter int DW    = 16,
    parameter int ACC_W = 18
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [DW-1:0]    o_res
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
`ifndef ACCUM_RELU_EN
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

    // Clamp the wide sum into the DW output range.
    always_comb begin
        o_res = i_acc[DW-1:0];
`ifdef ACCUM_RELU_EN
        if (i_acc[ACC_W-1]) begin
            o_res = '0;
        end else if (i_acc > MAX_V) begin
            o_res = MAX_V[DW-1:0];
        end
`else
        if (i_acc > MAX_V) begin
            o_res = MAX_V[DW-1:0];
        end else if (i_acc < MIN_V) begin
            o_res = MIN_V[DW-1:0];
        end
`endif
    end

endmodule

// File: rtl/channel_accum_blk.sv
// channel_accum_blk: after the conv layer finishes, reduces the IN_FM_CH
// partial-sum BRAMs plus a per-lane bias into one activated result word per
// address. Activation behaviour is selected by the ACCUM_RELU_EN build macro
// (see lane_act_sat).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for i_start; read address parked at 0
// S_READ  | one read per cycle, channel inner loop, address outer loop
// S_DRAIN | all reads issued; waiting for the final result write
// S_DONE  | one-cycle o_done pulse, then back to idle

`ifndef DW
`define DW 16
`endif

module channel_accum_blk
    import channel_accum_blk_pkg::*;
#(
    parameter int IN_FM_CH  = 3,
    parameter int LANES     = 4,
    parameter int DW        = `DW,
    parameter int OUT_DEPTH = 169
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [DW*LANES-1:0]          i_bias,
    output logic [$clog2(OUT_DEPTH)-1:0] o_psum_bram_r_addr,
    output logic [$clog2(IN_FM_CH):0]    o_psum_bram_r_sel,
    input  logic [DW*LANES-1:0]          i_psum_data,
    output logic [DW*LANES-1:0]          o_result,
    output logic                         o_result_w_en,
    output logic [$clog2(OUT_DEPTH)-1:0] o_result_w_addr,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int ACC_W = DW + $clog2(IN_FM_CH + 1);
    localparam int AW    = $clog2(OUT_DEPTH);
    localparam int SW    = $clog2(IN_FM_CH) + 1;
    localparam logic [SW-1:0] LAST_CH   = SW'(IN_FM_CH - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(OUT_DEPTH - 1);

    state_t                        state_q, state_d;
    logic [AW-1:0]                 rd_addr_q;
    logic [SW-1:0]                 rd_ch_q;
    logic [DW*LANES-1:0]           bias_q;
    logic                          last_rd;

    logic                          tag_vld_q  [PSUM_RD_LAT];
    logic [SW-1:0]                 tag_ch_q   [PSUM_RD_LAT];
    logic [AW-1:0]                 tag_addr_q [PSUM_RD_LAT];
    logic                          tag_vld;
    logic [SW-1:0]                 tag_ch;
    logic [AW-1:0]                 tag_addr;

    logic [LANES-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [LANES-1:0][DW-1:0]      act_res;
    logic [DW*LANES-1:0]           res_q;
    logic                          w_en_q;
    logic [AW-1:0]                 w_addr_q;

    assign last_rd  = (state_q == S_READ) && (rd_ch_q == LAST_CH) && (rd_addr_q == LAST_ADDR);
    assign tag_vld  = tag_vld_q[PSUM_RD_LAT-1];
    assign tag_ch   = tag_ch_q[PSUM_RD_LAT-1];
    assign tag_addr = tag_addr_q[PSUM_RD_LAT-1];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; DRAIN ends on the write of the last address.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_READ;
            S_READ:  if (last_rd) state_d = S_DRAIN;
            S_DRAIN: if (w_en_q && (w_addr_q == LAST_ADDR)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read address/channel counters and bias capture; start is only honoured in idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_addr_q <= '0;
            rd_ch_q   <= '0;
            bias_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        bias_q    <= i_bias;
                        rd_addr_q <= '0;
                        rd_ch_q   <= '0;
                    end
                end
                S_READ: begin
                    if (rd_ch_q == LAST_CH) begin
                        rd_ch_q <= '0;
                        if (rd_addr_q != LAST_ADDR) rd_addr_q <= rd_addr_q + AW'(1);
                    end else begin
                        rd_ch_q <= rd_ch_q + SW'(1);
                    end
                end
                S_DONE:  rd_addr_q <= '0;
                default: ;
            endcase
        end
    end

    // Valid/channel/address tag delayed to line up with the BRAM read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PSUM_RD_LAT; i++) begin
                tag_vld_q[i]  <= 1'b0;
                tag_ch_q[i]   <= '0;
                tag_addr_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0]  <= (state_q == S_READ);
            tag_ch_q[0]   <= rd_ch_q;
            tag_addr_q[0] <= rd_addr_q;
            for (int i = 1; i < PSUM_RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_ch_q[i]   <= tag_ch_q[i-1];
                tag_addr_q[i] <= tag_addr_q[i-1];
            end
        end
    end

    // Per-lane accumulate: channel 0 restarts from the bias, then activate.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [ACC_W-1:0] psum_x, bias_x, base_x;
        assign psum_x   = {{(ACC_W-DW){i_psum_data[l*DW+DW-1]}}, i_psum_data[l*DW +: DW]};
        assign bias_x   = {{(ACC_W-DW){bias_q[l*DW+DW-1]}}, bias_q[l*DW +: DW]};
        assign base_x   = (tag_ch == '0) ? bias_x : $signed(acc_q[l]);
        assign acc_d[l] = base_x + psum_x;

        lane_act_sat #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_act (
            .i_acc (acc_d[l]),
            .o_res (act_res[l])
        );
    end

    // Accumulator update and result write on the last channel of each address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q    <= '0;
            res_q    <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
        end else begin
            w_en_q <= 1'b0;
            if (tag_vld) begin
                acc_q <= acc_d;
                if (tag_ch == LAST_CH) begin
                    w_en_q   <= 1'b1;
                    w_addr_q <= tag_addr;
                    res_q    <= act_res;
                end
            end
        end
    end

    assign o_psum_bram_r_addr = rd_addr_q;
    assign o_psum_bram_r_sel  = rd_ch_q;
    assign o_result           = res_q;
    assign o_result_w_en      = w_en_q;
    assign o_result_w_addr    = w_addr_q;
    assign o_busy             = (state_q != S_IDLE);
    assign o_done             = (state_q == S_DONE);

endmodule

// File: doc/channel_accum_blk.md
Name: channel_accum_blk

Overview:
- Downstream of the convolution layer block.
- After the layer asserts done, this block reads the per-input-channel partial-sum BRAMs. For every address and lane it sums all IN_FM_CH partial sums plus a per-lane bias, then applies activation and saturation.
- It writes one final output-feature-map word per address into the result BRAM.
- One instance serves all LANES = PE_TO_USE*OUT_FM_CH result lanes in parallel.

Parameters:
- IN_FM_CH, 3, number of input-channel partial-sum BRAMs to reduce.
- LANES, 4, parallel result lanes (PE_TO_USE*OUT_FM_CH of the upstream layer).
- DW, `DW, signed width of one partial sum, bias and result lane.
- OUT_DEPTH, 169, words per partial-sum BRAM (BRAM_SIZE*OUT_SIZE upstream).
- ACC_W, DW+$clog2(IN_FM_CH+1), localparam, accumulator width; sums can never overflow it.

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_start, in, 1, single-cycle pulse, connected to the upstream o_done.
- i_bias, in, DW*LANES, signed per-lane bias; sampled on the accepted i_start.
- o_psum_bram_r_addr, out, $clog2(OUT_DEPTH), read address broadcast to all partial-sum BRAMs.
- o_psum_bram_r_sel, out, $clog2(IN_FM_CH)+1, channel index of the BRAM being read.
- i_psum_data, in, DW*LANES, signed read data of the selected BRAM; arrives 1 cycle after address/sel.
- o_result, out, DW*LANES, final activated lanes.
- o_result_w_en, out, 1, write strobe for the result BRAM.
- o_result_w_addr, out, $clog2(OUT_DEPTH), write address paired with o_result.
- o_busy, out, 1, high from the accepted start until o_done.
- o_done, out, 1, one-cycle pulse when the pass is complete.

Behaviour:
- Reset: every output is 0; the FSM enters S_IDLE; accumulators and counters are cleared.
- FSM: S_IDLE -> S_READ on i_start.
  - S_READ -> S_DRAIN after the read of the last address with the last channel is issued.
  - S_DRAIN -> S_DONE once the final write has been issued.
  - S_DONE -> S_IDLE unconditionally. o_done is 1 for exactly this cycle.
- Read sequence:
  - The channel counter is the inner loop (0..IN_FM_CH-1) and the address is the outer loop (0..OUT_DEPTH-1).
  - One read is issued per cycle, with no bubbles.
  - Total reads = OUT_DEPTH*IN_FM_CH.
- Accumulate:
  - A valid/channel tag is delayed 1 cycle to match BRAM latency.
  - Channel 0 data gives acc = sext(bias) + sext(psum).
  - Each later channel gives acc += sext(psum).
  - Each lane is independent.
- Write:
  - The cycle after the last channel's data arrives, o_result = act(acc), o_result_w_en = 1 and o_result_w_addr = that address.
  - w_en is 1 in every other cycle only when another address completes, i.e. every IN_FM_CH cycles.
- Latency:
  - i_start is sampled at cycle 0 and the first read is issued at cycle 1.
  - The first write occurs at cycle IN_FM_CH+2.
  - The last write occurs at cycle OUT_DEPTH*IN_FM_CH+2.
  - o_done occurs at cycle OUT_DEPTH*IN_FM_CH+3.
- IN_FM_CH=1: no stall; a write occurs every cycle, with result = act(bias+psum).
- Address counter: it never wraps. It stops at OUT_DEPTH-1, and o_psum_bram_r_addr returns to 0 in S_IDLE.
- i_start while busy: ignored, with no effect on bias, counters or outputs.
- Reset mid-pass: the pass is abandoned immediately; no further writes and no o_done.
- o_result holds its last value when w_en=0.

Optional Feature:
- Macro ACCUM_RELU_EN.
- When defined, act(x) = 0 for x<0 and min(x, 2^(DW-1)-1) otherwise.
- When undefined, act(x) = signed saturation of x to [-2^(DW-1), 2^(DW-1)-1]; negative results are preserved.

Decomposition:
- Shared package/defines header: `DW, FSM state encodings, and the BRAM read-latency constant (=1).
- One sub-module, lane_act_sat: a combinational ACC_W->DW activation/saturation per lane, instantiated LANES times with a generate.

Test Plan:
- IN_FM_CH=3, LANES=1, OUT_DEPTH=4, psums ch0..2 = 10, 20, -5, bias 7 at every address -> 4 writes of 32 at addresses 0..3. Writes at cycles 5, 8, 11, 14; o_done at cycle 15; o_busy for cycles 1..15.
- ACCUM_RELU_EN defined, psums -100, 20, 30 with bias 0 -> result 0. Without the macro -> result -50.
- DW=16, three psums of 32767 with bias 0 -> result 32767 in both builds. Three psums of -32768 -> -32768 without the macro, 0 with it.
- i_start pulsed again at cycle 6 of a pass -> ignored; exactly OUT_DEPTH writes and one o_done.
- i_rst asserted at cycle 7 -> from the next cycle all outputs are 0, with no w_en and no o_done. A fresh start afterwards completes normally from address 0.
- IN_FM_CH=1, OUT_DEPTH=3, psums 1, 2, 3, bias 4 -> writes of 5, 6, 7 on consecutive cycles 3..5; o_done at cycle 6.
